// File: rtl/sdio_wbmux.sv
// Wishbone fan-out from one upstream master to NCHAN SDIO/eMMC controllers,
// with card-detect debounce and local interrupt/status registers.
// Optional watchdog on channel transactions: define SDIO_WBMUX_WATCHDOG_EN.

module sdio_wbmux_cdb #(
  parameter int LGDEBOUNCE = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_det,
  output logic o_chg
);
  logic [LGDEBOUNCE-1:0] cnt_q, cnt_d;
  logic                  det_q, det_d;

  // Count cycles the input disagrees with the output; any agreement restarts it.
  always_comb begin
    cnt_d = '0;
    det_d = det_q;
    o_chg = 1'b0;
    if (i_raw != det_q) begin
      if (&cnt_q) begin
        det_d = i_raw;
        o_chg = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= '0;
      det_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      det_q <= det_d;
    end
  end

  assign o_det = det_q;
endmodule

module sdio_wbmux #(
  parameter int NCHAN      = 2,
  parameter int MW         = 32,
  parameter int LGDEBOUNCE = 16,
  parameter int LGWDT      = 10,
  localparam int CW        = (NCHAN > 1) ? $clog2(NCHAN) : 1,
  localparam int AW        = 4 + CW
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_wb_cyc,
  input  logic                  i_wb_stb,
  input  logic                  i_wb_we,
  input  logic [AW-1:0]         i_wb_addr,
  input  logic [MW-1:0]         i_wb_data,
  input  logic [MW/8-1:0]       i_wb_sel,
  output logic                  o_wb_stall,
  output logic                  o_wb_ack,
  output logic [MW-1:0]         o_wb_data,
  output logic [NCHAN-1:0]      o_ch_cyc,
  output logic [NCHAN-1:0]      o_ch_stb,
  output logic                  o_ch_we,
  output logic [2:0]            o_ch_addr,
  output logic [MW-1:0]         o_ch_data,
  output logic [MW/8-1:0]       o_ch_sel,
  input  logic [NCHAN-1:0]      i_ch_stall,
  input  logic [NCHAN-1:0]      i_ch_ack,
  input  logic [NCHAN*MW-1:0]   i_ch_data,
  input  logic [NCHAN-1:0]      i_ch_int,
  input  logic [NCHAN-1:0]      i_card_detect,
  output logic [NCHAN-1:0]      o_ch_card_detect,
  output logic                  o_int
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_LOCAL} state_t;

  localparam logic [CW:0]   NCH      = (CW+1)'(NCHAN);
  localparam logic [MW-1:0] LOWB     = MW'((1 << NCHAN) - 1);
  localparam logic [MW-1:0] INT_BITS = LOWB | (LOWB << 8);

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [MW-1:0]       data_q, data_d;
  logic [MW/8-1:0]     sel_q, sel_d;
  logic                ack_q, ack_d;
  logic [MW-1:0]       rdata_q, rdata_d;
  logic [MW-1:0]       mask_q, mask_d;
  logic [NCHAN-1:0]    sticky_q, sticky_d;
  logic                int_q, int_d;
  logic [15:0]         errcnt_q, errcnt_d;
  logic [LGWDT-1:0]    wdt_q, wdt_d;

  logic [NCHAN-1:0]    cd_chg, st_clr, ch_oh;
  logic [CW-1:0]       ch_q, in_ch;
  logic                ch_ok, in_ok, in_local, ch_ack, ch_stall;
  logic                wdt_exp, err_inc, err_clr;
  logic [MW-1:0]       ch_rdata, intstat, cdstat, wmask, wbits;

  for (genvar k = 0; k < NCHAN; k++) begin : g_cdb
    sdio_wbmux_cdb #(.LGDEBOUNCE(LGDEBOUNCE)) u_cdb (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_raw   (i_card_detect[k]),
      .o_det   (o_ch_card_detect[k]),
      .o_chg   (cd_chg[k])
    );
  end

  assign ch_q     = addr_q[AW-1:4];
  assign in_ch    = i_wb_addr[AW-1:4];
  assign ch_ok    = ({1'b0, ch_q} < NCH);
  assign in_ok    = ({1'b0, in_ch} < NCH);
  // Unpopulated channels are answered locally with zero data.
  assign in_local = i_wb_addr[3] || !in_ok;

  always_comb begin
    intstat = '0;
    intstat[NCHAN-1:0] = i_ch_int;
    intstat[8 +: NCHAN] = sticky_q;
    cdstat = '0;
    cdstat[NCHAN-1:0] = o_ch_card_detect;
    for (int b = 0; b < MW/8; b++) wmask[b*8 +: 8] = {8{i_wb_sel[b]}};
    wbits = i_wb_data & wmask;
  end

  always_comb begin
    ch_oh    = '0;
    ch_rdata = '0;
    for (int k = 0; k < NCHAN; k++) begin
      ch_oh[k] = ch_ok && (ch_q == CW'(k));
      if (ch_oh[k]) ch_rdata = i_ch_data[k*MW +: MW];
    end
    ch_ack   = |(i_ch_ack & ch_oh);
    ch_stall = |(i_ch_stall & ch_oh);
  end

`ifdef SDIO_WBMUX_WATCHDOG_EN
  assign wdt_exp = &wdt_q;
`else
  assign wdt_exp = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ack_d   = 1'b0;
    rdata_d = rdata_q;
    mask_d  = mask_q;
    st_clr  = '0;
    err_inc = 1'b0;
    err_clr = 1'b0;
    wdt_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (i_wb_cyc && i_wb_stb) begin
          we_d   = i_wb_we;
          addr_d = i_wb_addr;
          data_d = i_wb_data;
          sel_d  = i_wb_sel;
          if (in_local) begin
            // Local access completes here so the ack lands one cycle later.
            state_d = S_LOCAL;
            ack_d   = 1'b1;
            rdata_d = '0;
            if (in_ok) begin
              case (i_wb_addr[2:0])
                3'd0: begin
                  rdata_d = intstat;
                  if (i_wb_we) st_clr = wbits[8 +: NCHAN];
                end
                3'd1: begin
                  rdata_d = mask_q;
                  if (i_wb_we) mask_d = ((mask_q & ~wmask) | wbits) & INT_BITS;
                end
                3'd2: rdata_d = cdstat;
                3'd3: begin
                  rdata_d = MW'(errcnt_q);
                  err_clr = i_wb_we;
                end
                default: rdata_d = '0;
              endcase
            end
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ, S_WAIT: begin
        if (!i_wb_cyc) begin
          state_d = S_IDLE;
        end else if (ch_ack) begin
          state_d = S_IDLE;
          ack_d   = 1'b1;
          rdata_d = ch_rdata;
        end else if (wdt_exp) begin
          state_d = S_IDLE;
          ack_d   = 1'b1;
          rdata_d = {MW{1'b1}};
          err_inc = 1'b1;
        end else begin
          wdt_d = wdt_q + 1'b1;
          if (state_q == S_REQ && !ch_stall) state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifndef SDIO_WBMUX_WATCHDOG_EN
    wdt_d = '0;
`endif
  end

  always_comb begin
    sticky_d = (sticky_q & ~st_clr) | cd_chg;
    int_d    = |(intstat & mask_q);
    errcnt_d = errcnt_q;
    if (err_clr)                   errcnt_d = '0;
    else if (err_inc && ~&errcnt_q) errcnt_d = errcnt_q + 16'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      sel_q    <= '0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
      mask_q   <= '0;
      sticky_q <= '0;
      int_q    <= 1'b0;
      errcnt_q <= '0;
      wdt_q    <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      sel_q    <= sel_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      mask_q   <= mask_d;
      sticky_q <= sticky_d;
      int_q    <= int_d;
      errcnt_q <= errcnt_d;
      wdt_q    <= wdt_d;
    end
  end

  assign o_wb_stall = (state_q != S_IDLE);
  assign o_wb_ack   = ack_q;
  assign o_wb_data  = rdata_q;
  assign o_int      = int_q;
  assign o_ch_cyc   = (state_q == S_REQ || state_q == S_WAIT) ? ch_oh : '0;
  assign o_ch_stb   = (state_q == S_REQ) ? ch_oh : '0;
  assign o_ch_we    = we_q;
  assign o_ch_addr  = addr_q[2:0];
  assign o_ch_data  = data_q;
  assign o_ch_sel   = sel_q;
endmodule

// File: tb/tb_sdio_wbmux.sv
// Randomized bench for sdio_wbmux (NCHAN=3 so an unpopulated channel index exists)
// against a register/transaction-level model.

module tb_sdio_wbmux;
  localparam int NCHAN = 3;
  localparam int MW    = 32;
  localparam int AW    = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              wb_cyc, wb_stb, wb_we;
  logic [AW-1:0]     wb_addr;
  logic [MW-1:0]     wb_wdata;
  logic [3:0]        wb_sel;
  logic              wb_stall, wb_ack;
  logic [MW-1:0]     wb_rdata;
  logic [NCHAN-1:0]  ch_cyc, ch_stb;
  logic              ch_we;
  logic [2:0]        ch_addr;
  logic [MW-1:0]     ch_wdata;
  logic [3:0]        ch_sel;
  logic [NCHAN-1:0]  ch_stall, ch_ack, ch_int, card_det, ch_cd;
  logic [NCHAN*MW-1:0] ch_rdata;
  logic              irq;

  int checks = 0;
  int errors = 0;

  logic [31:0] mask_m = '0;
  logic [2:0]  sticky_m = '0;
  logic [2:0]  cd_m = '0;
  logic [15:0] errcnt_m = '0;

  always #5 clk = ~clk;

  sdio_wbmux #(.NCHAN(NCHAN), .MW(MW), .LGDEBOUNCE(4), .LGWDT(4)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb), .i_wb_we(wb_we), .i_wb_addr(wb_addr),
    .i_wb_data(wb_wdata), .i_wb_sel(wb_sel),
    .o_wb_stall(wb_stall), .o_wb_ack(wb_ack), .o_wb_data(wb_rdata),
    .o_ch_cyc(ch_cyc), .o_ch_stb(ch_stb), .o_ch_we(ch_we), .o_ch_addr(ch_addr),
    .o_ch_data(ch_wdata), .o_ch_sel(ch_sel),
    .i_ch_stall(ch_stall), .i_ch_ack(ch_ack), .i_ch_data(ch_rdata),
    .i_ch_int(ch_int), .i_card_detect(card_det),
    .o_ch_card_detect(ch_cd), .o_int(irq)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // One upstream transaction with a behavioural channel responder.
  // ackdly < 0 means the channel never acks.
  task automatic bus(input bit we, input logic [5:0] addr, input logic [31:0] wd,
                     input logic [3:0] sel, input int nstall, input int ackdly,
                     input logic [31:0] cdat, output logic [31:0] rd, output bit acked,
                     output int nstb, output logic [31:0] chd, output logic [3:0] cha);
    int ch, cnt, extra;
    bit pend, loc, stall_ok, other_ok;
    logic [2:0] oh;
    ch = int'(addr[5:4]);
    loc = addr[3] || (ch >= NCHAN);
    oh = loc ? 3'b000 : 3'(1 << ch);
    rd = '0; acked = 0; nstb = 0; pend = 0; cnt = 0; extra = 0;
    stall_ok = 1; other_ok = 1; chd = '0; cha = '0;
    @(negedge clk);
    wb_cyc = 1; wb_stb = 1; wb_we = we; wb_addr = addr; wb_wdata = wd; wb_sel = sel;
    for (int i = 1; i < 60 && !acked; i++) begin
      @(negedge clk);
      wb_stb = 0;
      ch_ack = '0;
      ch_stall = '0;
      if (wb_ack) begin
        acked = 1;
        rd = wb_rdata;
      end else if (!wb_stall) stall_ok = 0;
      if ((ch_cyc & ~oh) != 0) other_ok = 0;
      if (!acked && !loc && ch_stb[ch]) begin
        nstb++;
        if (nstb == 1) begin chd = ch_wdata; cha = {ch_we, ch_addr}; end
        ch_stall[ch] = (nstb <= nstall);
        if (nstb > nstall && ackdly >= 0) begin pend = 1; cnt = ackdly; end
      end
      if (pend) begin
        if (cnt == 0) begin
          ch_ack[ch] = 1'b1;
          ch_rdata[ch*MW +: MW] = cdat;
          pend = 0;
        end else cnt--;
      end
    end
    wb_cyc = 0;
    ch_ack = '0;
    ch_stall = '0;
    repeat (2) begin
      @(negedge clk);
      if (wb_ack) extra++;
    end
    chk("stall_held", 32'(stall_ok), 32'd1);
    chk("other_ch_idle", 32'(other_ok), 32'd1);
    chk("single_ack", 32'(extra), 32'd0);
  endtask

  function automatic logic [31:0] intstat_m();
    return {21'b0, sticky_m, 5'b0, ch_int};
  endfunction

  initial begin
    logic [31:0] rd, chd, wd, cd, expv;
    logic [3:0] cha, sel;
    logic [2:0] rg;
    logic [1:0] chv;
    bit acked, we;
    int nstb, kind, ns, ad, acks;

    rst = 1; wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_addr = '0; wb_wdata = '0; wb_sel = '0;
    ch_stall = '0; ch_ack = '0; ch_rdata = '0; ch_int = '0; card_det = '0;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_ack", 32'(wb_ack), 0);
    chk("rst_data", wb_rdata, 0);
    chk("rst_cyc", 32'(ch_cyc), 0);
    chk("rst_stall", 32'(wb_stall), 0);
    chk("rst_int", 32'(irq), 0);
    chk("rst_cd", 32'(ch_cd), 0);

    // Reset in the middle of a channel transaction aborts it silently.
    wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_addr = {2'd0, 1'b0, 3'd1};
    @(negedge clk); wb_stb = 0;
    @(negedge clk); rst = 1; ch_ack[0] = 1'b1;
    @(negedge clk); rst = 0; ch_ack = '0;
    @(negedge clk);
    chk("rstmid_ack", 32'(wb_ack), 0);
    chk("rstmid_cyc", 32'(ch_cyc), 0);
    chk("rstmid_stall", 32'(wb_stall), 0);
    wb_cyc = 0;

    // Read channel 1, ack three cycles after acceptance.
    bus(0, {2'd1, 1'b0, 3'h2}, 0, 4'hF, 0, 3, 32'h12345678, rd, acked, nstb, chd, cha);
    chk("rd1_ack", 32'(acked), 1);
    chk("rd1_data", rd, 32'h12345678);
    chk("rd1_nstb", 32'(nstb), 1);

    // Write channel 0 held off by 5 stall cycles.
    bus(1, {2'd0, 1'b0, 3'h5}, 32'hCAFEF00D, 4'hF, 5, 0, 32'h0, rd, acked, nstb, chd, cha);
    chk("wr0_ack", 32'(acked), 1);
    chk("wr0_nstb", 32'(nstb), 6);
    chk("wr0_data", chd, 32'hCAFEF00D);
    chk("wr0_addr", 32'(cha), 32'h0D);

    // Upstream cycle dropped in WAIT, then a late channel ack.
    @(negedge clk);
    wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_addr = {2'd0, 1'b0, 3'd1};
    @(negedge clk); wb_stb = 0;
    @(negedge clk);
    chk("abort_wait_cyc", 32'(ch_cyc), 32'b001);
    @(negedge clk); wb_cyc = 0;
    @(negedge clk);
    chk("abort_cyc", 32'(ch_cyc), 0);
    chk("abort_stall", 32'(wb_stall), 0);
    ch_ack[0] = 1'b1; ch_rdata[31:0] = 32'hDEADBEEF;
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      ch_ack = '0;
      if (wb_ack) acks++;
    end
    chk("abort_noack", 32'(acks), 0);

    // Channel that never answers.
    bus(0, {2'd2, 1'b0, 3'd0}, 0, 4'hF, 0, -1, 0, rd, acked, nstb, chd, cha);
`ifdef SDIO_WBMUX_WATCHDOG_EN
    chk("wdt_ack", 32'(acked), 1);
    chk("wdt_data", rd, 32'hFFFFFFFF);
    errcnt_m = 16'd1;
`else
    chk("nowdt_noack", 32'(acked), 0);
`endif
    bus(0, {2'd0, 1'b1, 3'd3}, 0, 4'hF, 0, 0, 0, rd, acked, nstb, chd, cha);
    chk("errcnt", rd, {16'b0, errcnt_m});

    // Card detect 0 rises: 16 stable cycles, then sticky flag and interrupt.
    bus(1, {2'd0, 1'b1, 3'd1}, 32'h100, 4'hF, 0, 0, 0, rd, acked, nstb, chd, cha);
    mask_m = 32'h100;
    card_det[0] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      chk("cd_rise", 32'(ch_cd[0]), 32'(k >= 16));
    end
    chk("cd_int", 32'(irq), 1);
    cd_m = 3'b001; sticky_m = 3'b001;
    bus(0, {2'd0, 1'b1, 3'd0}, 0, 4'hF, 0, 0, 0, rd, acked, nstb, chd, cha);
    chk("intstat_set", rd, 32'h100);
    bus(1, {2'd0, 1'b1, 3'd0}, 32'h100, 4'hF, 0, 0, 0, rd, acked, nstb, chd, cha);
    sticky_m = 3'b000;
    bus(0, {2'd0, 1'b1, 3'd0}, 0, 4'hF, 0, 0, 0, rd, acked, nstb, chd, cha);
    chk("intstat_clr", rd, 32'h0);
    chk("int_clr", 32'(irq), 0);

    // 10-cycle glitch on card detect 1 must be filtered out.
    card_det[1] = 1'b1;
    repeat (10) @(negedge clk);
    card_det[1] = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      chk("glitch_cd", 32'(ch_cd), 32'b001);
    end
    bus(0, {2'd0, 1'b1, 3'd0}, 0, 4'hF, 0, 0, 0, rd, acked, nstb, chd, cha);
    chk("glitch_flag", rd, 32'h0);

    // Randomized mix of channel, local and unpopulated-channel accesses.
    for (int t = 0; t < 60; t++) begin
      we = 1'($urandom); kind = int'($urandom % 4); chv = 2'($urandom % 3);
      rg = 3'($urandom); wd = $urandom; sel = 4'($urandom); cd = $urandom;
      ns = int'($urandom % 4); ad = int'($urandom % 4);
      ch_int = 3'($urandom);
      @(negedge clk);
      case (kind)
        0, 1: begin
          bus(we, {chv, 1'b0, rg}, wd, sel, ns, ad, cd, rd, acked, nstb, chd, cha);
          chk("rnd_ch_data", rd, cd);
          chk("rnd_ch_wdata", chd, wd);
          chk("rnd_ch_addr", 32'(cha), 32'({we, rg}));
        end
        2: begin
          case (rg)
            3'd0: expv = intstat_m();
            3'd1: expv = mask_m;
            3'd2: expv = {29'b0, cd_m};
            3'd3: expv = {16'b0, errcnt_m};
            default: expv = '0;
          endcase
          bus(we, {chv, 1'b1, rg}, wd, sel, ns, ad, cd, rd, acked, nstb, chd, cha);
          chk("rnd_loc_data", rd, expv);
          if (we) begin
            if (rg == 3'd0 && sel[1]) sticky_m = sticky_m & ~wd[10:8];
            if (rg == 3'd1) begin
              for (int b = 0; b < 4; b++) if (sel[b]) mask_m[b*8 +: 8] = wd[b*8 +: 8];
              mask_m = mask_m & 32'h707;
            end
            if (rg == 3'd3) errcnt_m = '0;
          end
        end
        default: begin
          bus(we, {2'd3, 1'($urandom), rg}, wd, sel, ns, ad, cd, rd, acked, nstb, chd, cha);
          chk("rnd_bad_data", rd, 0);
        end
      endcase
      chk("rnd_ack", 32'(acked), 1);
      chk("rnd_int", 32'(irq), 32'(|(intstat_m() & mask_m)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout reached");
    $fatal(1);
  end
endmodule
